// File: rtl/issue_stage_reg_pkg.sv
// issue_stage_reg_pkg: shared core widths, x0 address and issue-stage helper types.
package issue_stage_reg_pkg;
  localparam int CORE_XLEN = 32;
  localparam int CTRL_W = 8;
  localparam int REG_ADDR_W = 5;
  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  localparam reg_addr_t X0_ADDR = '0;
  // A destination only counts for forwarding when it really will be written.
  function automatic reg_addr_t fwd_dest(input logic valid, input logic wen, input reg_addr_t rd);
    return (valid && wen) ? rd : X0_ADDR;
  endfunction
endpackage

// File: rtl/issue_stage_reg_if.sv
// issue_stage_reg_if: ID-side capture bus and IS-side issue bus of the issue stage.
interface issue_stage_reg_if
  import issue_stage_reg_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
);
  logic id_valid_in;
  logic id_ready_out;
  logic [XLEN-1:0] id_pc_in;
  logic [XLEN-1:0] id_imm_in;
  logic [XLEN-1:0] id_ra_data_in;
  logic [XLEN-1:0] id_rb_data_in;
  reg_addr_t id_rd_addr_in;
  logic id_rd_wen_in;
  ctrl_t id_ctrl_in;
  logic [1:0] fwd_sel_in;
  logic [XLEN-1:0] fwd_data_in;
  logic flush_in;
  logic is_valid_out;
  logic is_ready_in;
  logic [XLEN-1:0] is_pc_out;
  logic [XLEN-1:0] is_imm_out;
  logic [XLEN-1:0] is_ra_out;
  logic [XLEN-1:0] is_rb_out;
  ctrl_t is_ctrl_out;
  logic is_rd_wen_out;
  reg_addr_t is_rd_addr_out;
  modport master (
    input id_valid_in, id_pc_in, id_imm_in, id_ra_data_in, id_rb_data_in,
    input id_rd_addr_in, id_rd_wen_in, id_ctrl_in, fwd_sel_in, fwd_data_in,
    input flush_in, is_ready_in,
    output id_ready_out, is_valid_out, is_pc_out, is_imm_out, is_ra_out,
    output is_rb_out, is_ctrl_out, is_rd_wen_out, is_rd_addr_out
  );
  modport slave (
    output id_valid_in, id_pc_in, id_imm_in, id_ra_data_in, id_rb_data_in,
    output id_rd_addr_in, id_rd_wen_in, id_ctrl_in, fwd_sel_in, fwd_data_in,
    output flush_in, is_ready_in,
    input id_ready_out, is_valid_out, is_pc_out, is_imm_out, is_ra_out,
    input is_rb_out, is_ctrl_out, is_rd_wen_out, is_rd_addr_out
  );
endinterface

// File: rtl/issue_stage_reg_entry.sv
// is_entry_reg: one payload register with load enable, cleared by async reset.
module is_entry_reg
  import issue_stage_reg_pkg::*;
#(
  parameter int W = CORE_XLEN
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] data_q, data_d;
  always_comb data_d = load ? d : data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) data_q <= '0;
    else data_q <= data_d;
  assign q = data_q;
endmodule

// File: rtl/issue_stage_reg.sv
// issue_stage_reg: two-entry (main + skid) issue register with capture-time operand forwarding.
module issue_stage_reg
  import issue_stage_reg_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
) (
  input logic clock_in,
  input logic reset_in,
  issue_stage_reg_if.master bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    ctrl_t ctrl;
    reg_addr_t rd;
    logic wen;
  } entry_t;
  entry_t cap, main_d, main_q, skid_q;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic id_fire, drain, main_load, skid_load;
  always_comb begin
    id_fire = bus.id_valid_in && !skid_valid_q;
    drain = main_valid_q && bus.is_ready_in;
    cap.pc = bus.id_pc_in;
    cap.imm = bus.id_imm_in;
    cap.ra = bus.fwd_sel_in[0] ? bus.fwd_data_in : bus.id_ra_data_in;
    cap.rb = bus.fwd_sel_in[1] ? bus.fwd_data_in : bus.id_rb_data_in;
    cap.ctrl = bus.id_ctrl_in;
    cap.rd = bus.id_rd_addr_in;
    cap.wen = bus.id_rd_wen_in;
    main_load = !bus.flush_in && (skid_valid_q ? drain : id_fire && (!main_valid_q || bus.is_ready_in));
    skid_load = !bus.flush_in && !skid_valid_q && main_valid_q && !bus.is_ready_in && id_fire;
    main_d = skid_valid_q ? skid_q : cap;
    main_valid_d = !bus.flush_in && (skid_valid_q || id_fire || (main_valid_q && !bus.is_ready_in));
    skid_valid_d = !bus.flush_in && (skid_valid_q ? !drain : skid_load);
  end
  always_ff @(posedge clock_in or negedge reset_in)
    if (!reset_in) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  is_entry_reg #(.W($bits(entry_t))) u_main (
    .clk(clock_in), .rst_n(reset_in), .load(main_load), .d(main_d), .q(main_q)
  );
  is_entry_reg #(.W($bits(entry_t))) u_skid (
    .clk(clock_in), .rst_n(reset_in), .load(skid_load), .d(cap), .q(skid_q)
  );
  assign bus.id_ready_out = !skid_valid_q;
  assign bus.is_valid_out = main_valid_q;
  assign bus.is_pc_out = main_q.pc;
  assign bus.is_imm_out = main_q.imm;
  assign bus.is_ra_out = main_q.ra;
  assign bus.is_rb_out = main_q.rb;
  assign bus.is_ctrl_out = main_q.ctrl;
  assign bus.is_rd_wen_out = main_valid_q && main_q.wen;
  assign bus.is_rd_addr_out = fwd_dest(main_valid_q, main_q.wen, main_q.rd);
endmodule
